// File: rtl/loom_clk_ctrl_pkg.sv
// Shared types and default widths for the Loom clock-enable controller.
package loom_clk_ctrl_pkg;

    localparam int CNT_W_DEF  = 64;
    localparam int STEP_W_DEF = 32;

    typedef enum logic [1:0] {
        OP_RUN     = 2'd0,
        OP_STEP    = 2'd1,
        OP_STOP    = 2'd2,
        OP_CLR_CNT = 2'd3
    } clk_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_STEP = 2'd2
    } clk_state_e;

    typedef enum logic [1:0] {
        HR_NONE      = 2'd0,
        HR_STEP_DONE = 2'd1,
        HR_HOST_STOP = 2'd2,
        HR_TRIGGER   = 2'd3
    } halt_reason_e;

endpackage

// File: rtl/loom_clk_ctrl.sv
// Clock-enable controller: decides on which host-clock cycles the emulated
// design's clock ticks, driven by host run/step/stop commands and triggers.
module loom_clk_ctrl
    import loom_clk_ctrl_pkg::*;
#(
    parameter int CNT_W  = CNT_W_DEF,
    parameter int STEP_W = STEP_W_DEF
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              cmd_valid_i,
    output logic              cmd_ready_o,
    input  logic [1:0]        cmd_op_i,
    input  logic [STEP_W-1:0] cmd_count_i,
    input  logic              stop_req_i,
    output logic              ce_o,
    output logic              running_o,
    output logic [CNT_W-1:0]  cycle_count_o,
    output logic              halt_o,
    output logic [1:0]        halt_reason_o,
    output logic              cmd_err_o
);

    localparam logic [1:0] S_IDLE = ST_IDLE;
    localparam logic [1:0] S_RUN  = ST_RUN;
    localparam logic [1:0] S_STEP = ST_STEP;

    clk_op_e           op;
    logic [1:0]        state_q, state_d;
    logic [STEP_W-1:0] remaining_q, remaining_d;
    logic [CNT_W-1:0]  count_q;
    logic              ce_q;
    logic              halt_q, halt_d;
    logic [1:0]        reason_q, reason_d;
    logic              err_q, err_d;
    logic              clr_cnt;
    logic              step_done;

    assign op            = clk_op_e'(cmd_op_i);
    assign cmd_ready_o   = 1'b1;
    assign ce_o          = ce_q;
    assign running_o     = (state_q != S_IDLE);
    assign cycle_count_o = count_q;
    assign halt_o        = halt_q;
    assign halt_reason_o = reason_q;
    assign cmd_err_o     = err_q;

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        halt_d      = 1'b0;
        reason_d    = reason_q;
        err_d       = 1'b0;
        clr_cnt     = 1'b0;
        step_done   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (cmd_valid_i) begin
                    case (op)
                        OP_RUN:  state_d = S_RUN;
                        OP_STEP: begin
                            if (cmd_count_i != '0) begin
                                state_d     = S_STEP;
                                remaining_d = cmd_count_i;
                            end else begin
                                halt_d   = 1'b1;
                                reason_d = HR_STEP_DONE;
                            end
                        end
                        OP_STOP: state_d = S_IDLE;
                        OP_CLR_CNT: begin
                            clr_cnt  = 1'b1;
                            reason_d = HR_NONE;
                        end
                        default: state_d = S_IDLE;
                    endcase
                end
            end
            default: begin
                if (state_q == S_STEP && ce_q) begin
                    remaining_d = remaining_q - STEP_W'(1);
                    step_done   = (remaining_q == STEP_W'(1));
                end
                if (cmd_valid_i && op != OP_STOP) begin
                    err_d = 1'b1;
                end
                // Coincident stop causes resolve as TRIGGER > HOST_STOP > STEP_DONE.
                if (stop_req_i || (cmd_valid_i && op == OP_STOP) || step_done) begin
                    state_d     = S_IDLE;
                    remaining_d = '0;
                    halt_d      = 1'b1;
                    if (stop_req_i) begin
                        reason_d = HR_TRIGGER;
                    end else if (cmd_valid_i && op == OP_STOP) begin
                        reason_d = HR_HOST_STOP;
                    end else begin
                        reason_d = HR_STEP_DONE;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            ce_q        <= 1'b0;
            remaining_q <= '0;
            count_q     <= '0;
            halt_q      <= 1'b0;
            reason_q    <= HR_NONE;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            ce_q        <= (state_d != S_IDLE);
            remaining_q <= remaining_d;
            halt_q      <= halt_d;
            reason_q    <= reason_d;
            err_q       <= err_d;
            if (clr_cnt) begin
                count_q <= '0;
            end else if (ce_q) begin
                count_q <= count_q + CNT_W'(1);
            end
        end
    end

endmodule
